// File: rtl/string_pkg.sv
// Shared constants for the ASCII expression stream: character codes,
// operator encoding and the transmit FSM state encoding.
// Optional feature macro: STR_TERMINATOR_EN (adds the '=' terminator state).
package string_pkg;

    localparam logic [7:0] CH_0    = 8'd48;
    localparam logic [7:0] CH_PLUS = 8'd43;
    localparam logic [7:0] CH_MUL  = 8'd42;
    localparam logic [7:0] CH_EQ   = 8'd61;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIGIT = 3'd1,
        ST_OP    = 3'd2,
        ST_DONE  = 3'd4
`ifdef STR_TERMINATOR_EN
        ,
        ST_TERM  = 3'd3
`endif
    } state_t;

endpackage

// File: rtl/expr_char_enc.sv
// Maps one expression symbol (digit, operator or terminator) to its ASCII byte.
// Purely combinational so recogniser-side checkers can reuse it.
module expr_char_enc
    import string_pkg::*;
#(
    parameter int unsigned CW = 8
) (
    input  logic          is_op,
    input  logic          op_bit,
    input  logic [3:0]    digit,
    input  logic          is_term,
    output logic [CW-1:0] ch_c
);

    // Terminator wins over operator, operator wins over digit
    always_comb begin
        ch_c = CW'(CH_0) + CW'(digit);
        if (is_term) begin
            ch_c = CW'(CH_EQ);
        end else if (is_op) begin
            ch_c = (op_bit == OP_MUL) ? CW'(CH_MUL) : CW'(CH_PLUS);
        end
    end

endmodule

// File: rtl/expr_string_gen.sv
// Transmit side of the ASCII expression stream: latches an expression on start
// and emits one ASCII character per valid/ready handshake.
// Optional feature macro: STR_TERMINATOR_EN appends '=' after the last digit.
module expr_string_gen
    import string_pkg::*;
#(
    parameter int unsigned MAX_TERMS = 8,
    parameter int unsigned CW        = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   start,
    input  logic [3:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    input  logic                   out_ready,
    output logic [CW-1:0]          out_char,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned IW = $clog2(MAX_TERMS + 1);
    localparam int unsigned DW = 4 * MAX_TERMS;
    localparam int unsigned OW = MAX_TERMS - 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [3:0]      nt_q, nt_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [OW-1:0]   ops_q, ops_d;

    logic            valid_d, busy_d, done_d, err_d;
    logic            load_bad_c, xfer_c, last_c;
    logic [3:0]      dig_sel_c;
    logic            op_sel_c;
    logic            is_op_c, is_term_c;
    logic [CW-1:0]   ch_c;

    assign xfer_c = out_valid && out_ready;
    assign last_c = (32'(idx_q) + 32'd1) == 32'(nt_q);

    // Validate a load request: operand count range and every used digit <= 9
    always_comb begin
        load_bad_c = (n_terms == 4'd0) || (32'(n_terms) > MAX_TERMS);
        for (int i = 0; i < int'(MAX_TERMS); i++) begin
            if ((i < int'(n_terms)) && (digits[4*i +: 4] > 4'd9)) begin
                load_bad_c = 1'b1;
            end
        end
    end

    // Next-state, load registers, index and next output values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nt_d    = nt_q;
        dig_d   = dig_q;
        ops_d   = ops_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (load_bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_DIGIT;
                        idx_d   = '0;
                        nt_d    = n_terms;
                        dig_d   = digits;
                        ops_d   = ops;
                    end
                end
            end
            ST_DIGIT: begin
                if (xfer_c) begin
                    if (last_c) begin
`ifdef STR_TERMINATOR_EN
                        state_d = ST_TERM;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_OP;
                    end
                end
            end
            ST_OP: begin
                if (xfer_c) begin
                    state_d = ST_DIGIT;
                    idx_d   = idx_q + IW'(1);
                end
            end
`ifdef STR_TERMINATOR_EN
            ST_TERM: begin
                if (xfer_c) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d = (state_d == ST_DIGIT) || (state_d == ST_OP)
`ifdef STR_TERMINATOR_EN
                  || (state_d == ST_TERM)
`endif
                  ;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // Pick the operand and operator addressed by the next index
    always_comb begin
        dig_sel_c = 4'd0;
        op_sel_c  = 1'b0;
        for (int i = 0; i < int'(MAX_TERMS); i++) begin
            if (idx_d == IW'(i)) dig_sel_c = dig_d[4*i +: 4];
        end
        for (int i = 0; i < int'(OW); i++) begin
            if (idx_d == IW'(i)) op_sel_c = ops_d[i];
        end
    end

    assign is_op_c = (state_d == ST_OP);
`ifdef STR_TERMINATOR_EN
    assign is_term_c = (state_d == ST_TERM);
`else
    assign is_term_c = 1'b0;
`endif

    expr_char_enc #(
        .CW (CW)
    ) u_enc (
        .is_op   (is_op_c),
        .op_bit  (op_sel_c),
        .digit   (dig_sel_c),
        .is_term (is_term_c),
        .ch_c    (ch_c)
    );

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load registers, term index and registered outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            idx_q     <= '0;
            nt_q      <= '0;
            dig_q     <= '0;
            ops_q     <= '0;
            out_char  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            nt_q      <= nt_d;
            dig_q     <= dig_d;
            ops_q     <= ops_d;
            out_char  <= valid_d ? ch_c : '0;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule
